// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex 7-segment driver with frame-synchronous double-buffered load.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_DIG = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    enable_i,
  output logic                    pending_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_o
);

  localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PS_W-1:0]         prescaler;
  logic [IDX_W-1:0]        index;
  logic                    tick;
  logic                    frame_end;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   dig_q;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = 7'b0111111;
      4'h1:    decode = 7'b0000110;
      4'h2:    decode = 7'b1011011;
      4'h3:    decode = 7'b1001111;
      4'h4:    decode = 7'b1100110;
      4'h5:    decode = 7'b1101101;
      4'h6:    decode = 7'b1111101;
      4'h7:    decode = 7'b0000111;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1100111;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b1111100;
      4'hC:    decode = 7'b0111001;
      4'hD:    decode = 7'b1011110;
      4'hE:    decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  assign tick      = (prescaler == PS_LAST);
  assign frame_end = tick && (index == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end
  end

  // NOTE: shadow and display registers are reset so the first frame after reset is a defined all-zero value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
    end else begin
      // On a boundary collision the display takes the old shadow while the shadow takes the new data.
      if (frame_end && pending) begin
        disp_data <= shadow_data;
        disp_dp   <= shadow_dp;
      end
      if (load_i) begin
        shadow_data <= data_i;
        shadow_dp   <= dp_i;
        pending     <= 1'b1;
      end else if (frame_end) begin
        pending     <= 1'b0;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (disp_data[4*k +: 4] == 4'h0);
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  assign cur_nib = disp_data[{index, 2'b00} +: 4];
  assign dig_sel = NUM_DIGITS'(1) << index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      dig_q <= '0;
    end else if (!enable_i) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      dig_q <= '0;
    end else begin
      seg_q <= blank[index] ? 7'b0000000 : decode(cur_nib);
      dp_q  <= disp_dp[index];
      dig_q <= dig_sel;
    end
  end

  // Polarity is applied after the register so inactive levels are correct during reset too.
  assign seg_o     = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
  assign dp_o      = ACTIVE_LOW_SEG ? ~dp_q  : dp_q;
  assign dig_o     = ACTIVE_LOW_DIG ? ~dig_q : dig_q;
  assign pending_o = pending;

endmodule
